// File: rtl/cardinal_dmem_if.sv
// Core <-> data-memory request/response bus for cardinal_dmem.
// Every vector is big-endian: bit [0] is the MSB.
interface cardinal_dmem_if;
    logic        mem_en;
    logic        mem_wr_en;
    logic [0:31] mem_addr;
    logic [0:63] wr_data;
    logic [0:63] rd_data;

    modport master (output mem_en, mem_wr_en, mem_addr, wr_data, input rd_data);
    modport slave  (input mem_en, mem_wr_en, mem_addr, wr_data, output rd_data);
endinterface

// File: rtl/cardinal_dmem.sv
// Data memory for the cardinal core: 1-cycle registered loads, self-clear after reset, sticky address
// error, saturating access counters. Define DMEM_PARITY_EN for per-byte even parity with error injection.
module cardinal_dmem #(
    parameter int ADDR_W = 6,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    cardinal_dmem_if.slave   bus,
`ifdef DMEM_PARITY_EN
    input  logic             par_inject,
`endif
    output logic             init_busy,
    output logic             addr_err,
    output logic [0:CNT_W-1] rd_cnt,
    output logic [0:CNT_W-1] wr_cnt,
    output logic             par_err
);

    localparam int DEPTH = 2 ** ADDR_W;
`ifdef DMEM_PARITY_EN
    localparam int WORD_W = 72;
`else
    localparam int WORD_W = 64;
`endif

    typedef enum logic {CLEAR, READY} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic [0:63]       rd_data_q, rd_data_d;
    logic              init_busy_q, init_busy_d;
    logic              addr_err_q, addr_err_d;
    logic [0:CNT_W-1]  rd_cnt_q, rd_cnt_d;
    logic [0:CNT_W-1]  wr_cnt_q, wr_cnt_d;
`ifdef DMEM_PARITY_EN
    logic              par_err_q, par_err_d;
`endif

    logic [0:WORD_W-1] mem [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_widx;
    logic [0:WORD_W-1] mem_wdata;
    logic [0:WORD_W-1] rd_word;

    logic [ADDR_W-1:0] req_idx;
    logic              misaligned;
    logic              out_of_range;

    // Byte address -> word index; the low three bits select a byte and must be zero.
    assign req_idx      = bus.mem_addr[29-ADDR_W:28];
    assign misaligned   = |bus.mem_addr[29:31];
    assign out_of_range = |bus.mem_addr[0:28-ADDR_W];
    assign rd_word      = mem[req_idx];

`ifdef DMEM_PARITY_EN
    function automatic logic [0:7] byte_parity(input logic [0:63] d);
        logic [0:7] p;
        for (int b = 0; b < 8; b++) p[b] = ^d[8*b +: 8];
        return p;
    endfunction
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case leaves one unassigned (no latches).
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        rd_data_d   = rd_data_q;
        addr_err_d  = addr_err_q;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;
`ifdef DMEM_PARITY_EN
        par_err_d   = par_err_q;
`endif
        mem_we      = 1'b0;
        mem_widx    = req_idx;
        mem_wdata   = '0;

        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_widx  = clr_idx_q;
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == ADDR_W'(DEPTH - 1)) state_d = READY;
            end
            READY: begin
                if (bus.mem_en) begin
                    if (misaligned || out_of_range) begin
                        addr_err_d = 1'b1;
                        if (!bus.mem_wr_en) rd_data_d = '0;
                    end else if (bus.mem_wr_en) begin
                        mem_we = 1'b1;
`ifdef DMEM_PARITY_EN
                        mem_wdata = {bus.wr_data, byte_parity(bus.wr_data) ^ {8{par_inject}}};
`else
                        mem_wdata = bus.wr_data;
`endif
                        if (~&wr_cnt_q) wr_cnt_d = wr_cnt_q + 1'b1;
                    end else begin
                        rd_data_d = rd_word[0:63];
                        if (~&rd_cnt_q) rd_cnt_d = rd_cnt_q + 1'b1;
`ifdef DMEM_PARITY_EN
                        if (byte_parity(rd_word[0:63]) != rd_word[64:71]) par_err_d = 1'b1;
`endif
                    end
                end
            end
            default: state_d = CLEAR;
        endcase

        init_busy_d = (state_d == CLEAR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= CLEAR;
            clr_idx_q   <= '0;
            rd_data_q   <= '0;
            init_busy_q <= 1'b1;
            addr_err_q  <= 1'b0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
`ifdef DMEM_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            rd_data_q   <= rd_data_d;
            init_busy_q <= init_busy_d;
            addr_err_q  <= addr_err_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
`ifdef DMEM_PARITY_EN
            par_err_q   <= par_err_d;
`endif
        end
    end

    // NOTE: the array has no reset branch; the CLEAR sweep zeroes it, which keeps it mappable to RAM.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) mem[mem_widx] <= mem_wdata;
    end

    assign bus.rd_data = rd_data_q;
    assign init_busy   = init_busy_q;
    assign addr_err    = addr_err_q;
    assign rd_cnt      = rd_cnt_q;
    assign wr_cnt      = wr_cnt_q;
`ifdef DMEM_PARITY_EN
    assign par_err     = par_err_q;
`else
    assign par_err     = 1'b0;
`endif

endmodule

// File: tb/tb_cardinal_dmem.sv
// Scoreboard bench for cardinal_dmem: the driver queues expected values tagged with the cycle they are due,
// and an independent monitor compares them one time step after each rising edge.
module tb_cardinal_dmem;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef DMEM_PARITY_EN
    localparam bit PAR_BUILD = 1'b1;
`else
    localparam bit PAR_BUILD = 1'b0;
`endif

    typedef enum int {K_RD_DATA, K_INIT_BUSY, K_ADDR_ERR, K_RD_CNT, K_WR_CNT, K_PAR_ERR} kind_e;
    typedef struct {
        int          at;
        kind_e       kind;
        logic [63:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             par_inject = 1'b0;
    logic             init_busy;
    logic             addr_err;
    logic             par_err;
    logic [0:CNT_W-1] rd_cnt;
    logic [0:CNT_W-1] wr_cnt;

    int          cyc   = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          exp_rd = 0;
    int          exp_wr = 0;
    bit          exp_aerr = 1'b0;
    bit          exp_par  = 1'b0;
    logic [63:0] last_rd  = 64'h0;

    cardinal_dmem_if bus();

    cardinal_dmem #(.ADDR_W(6), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
`ifdef DMEM_PARITY_EN
        .par_inject(par_inject),
`endif
        .init_busy (init_busy),
        .addr_err  (addr_err),
        .rd_cnt    (rd_cnt),
        .wr_cnt    (wr_cnt),
        .par_err   (par_err)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] actual(input kind_e k);
        case (k)
            K_RD_DATA:   return bus.rd_data;
            K_INIT_BUSY: return 64'(init_busy);
            K_ADDR_ERR:  return 64'(addr_err);
            K_RD_CNT:    return 64'(rd_cnt);
            K_WR_CNT:    return 64'(wr_cnt);
            default:     return 64'(par_err);
        endcase
    endfunction

    // Monitor: compare every queued expectation that falls due on this cycle.
    always begin
        @(posedge clk);
        #1;
        cyc++;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at <= cyc) begin
                n_cmp++;
                if (sb[i].at < cyc) begin
                    n_bad++;
                    $display("FAIL %s: expectation due cycle %0d was checked late at %0d", sb[i].name, sb[i].at, cyc);
                end else if (actual(sb[i].kind) !== sb[i].val) begin
                    n_bad++;
                    $display("FAIL %s @cycle %0d: got %h, expected %h", sb[i].name, cyc, actual(sb[i].kind), sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic int sat(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    task automatic push(input int dly, input kind_e k, input logic [63:0] v, input string nm);
        sb.push_back('{at: cyc + dly, kind: k, val: v, name: nm});
    endtask

    task automatic drive(input logic rst, input logic en, input logic we, input logic [31:0] addr,
                         input logic [63:0] data, input logic inj);
        @(negedge clk);
        reset         = rst;
        bus.mem_en    = en;
        bus.mem_wr_en = we;
        bus.mem_addr  = addr;
        bus.wr_data   = data;
        par_inject    = inj;
    endtask

    task automatic expect_reset_state(input int dly);
        exp_rd = 0; exp_wr = 0; exp_aerr = 1'b0; exp_par = 1'b0; last_rd = 64'h0;
        push(dly, K_RD_DATA,   64'h0, "rst_rd_data");
        push(dly, K_INIT_BUSY, 64'h1, "rst_init_busy");
        push(dly, K_ADDR_ERR,  64'h0, "rst_addr_err");
        push(dly, K_RD_CNT,    64'h0, "rst_rd_cnt");
        push(dly, K_WR_CNT,    64'h0, "rst_wr_cnt");
        push(dly, K_PAR_ERR,   64'h0, "rst_par_err");
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [63:0] data, input bit ok);
        drive(1'b0, 1'b1, 1'b0, addr, 64'h0, 1'b0);
        if (ok) begin
            exp_rd  = sat(exp_rd);
            last_rd = data;
        end else begin
            exp_aerr = 1'b1;
            last_rd  = 64'h0;
        end
        push(1, K_RD_DATA,  last_rd,         "load_data");
        push(1, K_RD_CNT,   64'(exp_rd),     "rd_cnt");
        push(1, K_ADDR_ERR, 64'(exp_aerr),   "addr_err");
        push(1, K_PAR_ERR,  64'(exp_par),    "par_err");
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [63:0] data, input logic inj, input bit ok);
        drive(1'b0, 1'b1, 1'b1, addr, data, inj);
        if (ok) exp_wr = sat(exp_wr);
        else    exp_aerr = 1'b1;
        push(1, K_RD_DATA,  last_rd,       "store_holds_rd_data");
        push(1, K_WR_CNT,   64'(exp_wr),   "wr_cnt");
        push(1, K_ADDR_ERR, 64'(exp_aerr), "addr_err");
    endtask

    task automatic do_idle();
        drive(1'b0, 1'b0, 1'b1, 32'h10, 64'hBAD0_BAD0_BAD0_BAD0, 1'b0);
        push(1, K_RD_DATA, last_rd,     "idle_holds_rd_data");
        push(1, K_WR_CNT,  64'(exp_wr), "idle_wr_cnt");
    endtask

    initial begin
        bus.mem_en    = 1'b0;
        bus.mem_wr_en = 1'b0;
        bus.mem_addr  = 32'h0;
        bus.wr_data   = 64'h0;

        // Three reset edges, then a full clear sweep with stray requests that must be ignored.
        expect_reset_state(3);
        repeat (3) @(posedge clk);
        for (int c = 1; c <= 64; c++) begin
            if (c == 10)      drive(1'b0, 1'b1, 1'b1, 32'h08, 64'hDEAD_BEEF_0000_0001, 1'b0);
            else if (c == 11) drive(1'b0, 1'b1, 1'b0, 32'h28, 64'h0, 1'b0);
            else              drive(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0);
            push(1, K_INIT_BUSY, (c < 64) ? 64'h1 : 64'h0, "init_busy_clear");
            if (c == 11) begin
                push(1, K_RD_DATA, 64'h0, "clear_rd_data");
                push(1, K_RD_CNT,  64'h0, "clear_rd_cnt");
                push(1, K_WR_CNT,  64'h0, "clear_wr_cnt");
            end
        end

        do_load(32'h28, 64'h0, 1'b1);
        do_load(32'h08, 64'h0, 1'b1);

        // Store then immediate load of the same word; idle cycles and stores keep rd_data.
        do_store(32'h10, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1);
        do_load(32'h10, 64'h0123_4567_89AB_CDEF, 1'b1);
        do_idle();
        do_store(32'h18, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0, 1'b1);
        do_load(32'h18, 64'hA5A5_5A5A_0F0F_F0F0, 1'b1);
        do_store(32'h1F8, 64'hCAFE_F00D_1234_5678, 1'b0, 1'b1);
        do_load(32'h1F8, 64'hCAFE_F00D_1234_5678, 1'b1);

        // Bad addresses: misaligned load, out-of-range store/load; array must be untouched.
        do_load(32'h0C, 64'h0, 1'b0);
        do_store(32'h200, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        do_store(32'h14, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
        do_load(32'h8000_0010, 64'h0, 1'b0);
        do_load(32'h00, 64'h0, 1'b1);
        do_load(32'h10, 64'h0123_4567_89AB_CDEF, 1'b1);

        // Load counter saturates at all-ones.
        for (int i = 0; i < 20; i++) do_load(32'h1F8, 64'hCAFE_F00D_1234_5678, 1'b1);

        // Parity injection: flags par_err only when the parity option is built in.
        do_store(32'h18, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        exp_par = PAR_BUILD;
        do_load(32'h18, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        do_idle();
        push(1, K_PAR_ERR, 64'(exp_par), "par_err_sticky");

        // Reset mid-clear restarts the sweep from scratch.
        drive(1'b1, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0);
        expect_reset_state(1);
        for (int c = 1; c <= 20; c++) begin
            if (c == 5) drive(1'b0, 1'b1, 1'b1, 32'h08, 64'h5555_AAAA_5555_AAAA, 1'b0);
            else        drive(c == 20, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0);
            push(1, K_INIT_BUSY, 64'h1, "init_busy_pre_restart");
        end
        push(1, K_WR_CNT, 64'h0, "restart_wr_cnt");
        for (int c = 1; c <= 64; c++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0);
            push(1, K_INIT_BUSY, (c < 64) ? 64'h1 : 64'h0, "init_busy_restart");
        end
        do_load(32'h10, 64'h0, 1'b1);
        do_load(32'h08, 64'h0, 1'b1);
        do_load(32'h1F8, 64'h0, 1'b1);

        repeat (3) do_idle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0);
        @(posedge clk);
        #2;
        foreach (sb[i]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: expectation due cycle %0d never checked", sb[i].name, sb[i].at);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
